// File: rtl/bp_pkg.sv
// Shared definitions for the fetch branch predictor: 2-bit direction
// counter encodings and the saturating counter update function.
package bp_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } bp_ctr_e;

  // Move one step toward taken or not-taken, holding at either end.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic for one 2-bit saturating direction counter.
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  // Pure combinational step of the counter.
  always_comb begin
    ctr_o = sat_update(ctr_i, taken_i);
  end

endmodule

// File: rtl/fetch_branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters for the fetch stage.
// Lookup is combinational on PCF; training happens on the execute-stage
// resolution. Optional build macro BP_STATS_EN adds branch and mispredict
// counters (BrCount, MispCount).
module fetch_branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        UpdValidE,
  input  logic [31:0] UpdPCE,
  input  logic        UpdTakenE,
  input  logic [31:0] UpdTargetE,
  input  logic [31:0] UpdPCPlus4E,
  input  logic        UpdPredTakenE,
  input  logic [31:0] UpdPredTargetE,
  output logic        RedirectE,
  output logic [31:0] RedirectPCE
`ifdef BP_STATS_EN
  ,
  output logic [31:0] BrCount,
  output logic [31:0] MispCount
`endif
);

  localparam int TAG_W = 32 - IDX_W - 2;

  logic             valid_q  [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             hit_f, hit_e;
  logic [1:0]       ctr_step;
  logic [1:0]       ctr_d;
  logic             ctr_we_d, alloc_d, tgt_we_d;

  // Low PC bits are always zero for aligned fetch and play no part here.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PCF[1:0], UpdPCE[1:0]};

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[31:IDX_W+2];
  assign idx_e = UpdPCE[IDX_W+1:2];
  assign tag_e = UpdPCE[31:IDX_W+2];

  // Fetch-side lookup: predict taken only on a tag hit with a taken-leaning counter.
  always_comb begin
    hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    PredTakenF  = hit_f && ctr_q[idx_f][1];
    PredTargetF = PredTakenF ? target_q[idx_f] : 32'd0;
  end

  // Execute-side mispredict detection and corrected fetch PC.
  always_comb begin
    RedirectE   = UpdValidE && ((UpdTakenE != UpdPredTakenE) ||
                                (UpdTakenE && (UpdTargetE != UpdPredTargetE)));
    RedirectPCE = UpdTakenE ? UpdTargetE : UpdPCPlus4E;
  end

  bp_sat_counter u_sat_counter (
    .ctr_i   (ctr_q[idx_e]),
    .taken_i (UpdTakenE),
    .ctr_o   (ctr_step)
  );

  // Decide what the resolving branch does to its entry: train on hit,
  // allocate on a taken miss, otherwise leave the table alone.
  always_comb begin
    hit_e    = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    ctr_we_d = 1'b0;
    alloc_d  = 1'b0;
    tgt_we_d = 1'b0;
    ctr_d    = ctr_step;
    if (UpdValidE) begin
      if (hit_e) begin
        ctr_we_d = 1'b1;
        tgt_we_d = UpdTakenE;
      end else if (UpdTakenE) begin
        ctr_we_d = 1'b1;
        alloc_d  = 1'b1;
        tgt_we_d = 1'b1;
        ctr_d    = CTR_WT;
      end
    end
  end

  // Table storage; reset only clears valid bits and parks counters at weakly
  // not-taken, tags and targets are left as they were.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else begin
      if (ctr_we_d) ctr_q[idx_e] <= ctr_d;
      if (tgt_we_d) target_q[idx_e] <= UpdTargetE;
      if (alloc_d) begin
        valid_q[idx_e] <= 1'b1;
        tag_q[idx_e]   <= tag_e;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d, misp_cnt_q, misp_cnt_d;

  // Saturating event counters for branches seen and mispredicts.
  always_comb begin
    br_cnt_d   = br_cnt_q;
    misp_cnt_d = misp_cnt_q;
    if (UpdValidE && (br_cnt_q != 32'hFFFF_FFFF)) br_cnt_d = br_cnt_q + 32'd1;
    if (RedirectE && (misp_cnt_q != 32'hFFFF_FFFF)) misp_cnt_d = misp_cnt_q + 32'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_q   <= 32'd0;
      misp_cnt_q <= 32'd0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      misp_cnt_q <= misp_cnt_d;
    end
  end

  assign BrCount   = br_cnt_q;
  assign MispCount = misp_cnt_q;
`endif

endmodule
